// File: rtl/branch_predictor_unit.sv
`default_nettype none
// ============================================================================
//  Module      : branch_predictor_unit
//  Description : Branch resolution and dynamic prediction for the RISC-V
//                pipeline. A direct-mapped table of 2-bit saturating counters
//                with a tagged target buffer is looked up in IF. EX resolves
//                the branch, trains the table and flags mispredictions for
//                the hazard unit. Mispredictions are tallied in a saturating
//                counter.
//  Revision    : 1.0 - initial release
// ============================================================================
module branch_predictor_unit #(
    parameter int XLEN     = 32,
    parameter int IDX_BITS = 6,
    parameter int TAG_BITS = 8,
    parameter int CNT_W    = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [XLEN-1:0]  if_pc,
    output logic             pred_taken,
    output logic [XLEN-1:0]  pred_target,
    input  logic             ex_branch,
    input  logic [2:0]       ex_funct3,
    input  logic             ex_zero,
    input  logic             ex_sign,
    input  logic [XLEN-1:0]  ex_pc,
    input  logic [XLEN-1:0]  ex_target,
    input  logic             ex_pred_taken,
    input  logic [XLEN-1:0]  ex_pred_target,
    output logic             branch_taken,
    output logic             mispredict,
    output logic [CNT_W-1:0] mispredict_count
);

    localparam int               c_DEPTH   = 1 << IDX_BITS;
    localparam int               c_TAG_LSB = IDX_BITS + 2;
    localparam int               c_TAG_MSB = IDX_BITS + TAG_BITS + 1;
    localparam logic [CNT_W-1:0] c_CNT_MAX = {CNT_W{1'b1}};
    localparam logic [1:0]       c_CTR_MAX = 2'b11;
    localparam logic [1:0]       c_CTR_MIN = 2'b00;
    localparam logic [1:0]       c_CTR_RST = 2'b01;
    localparam logic [1:0]       c_CTR_NEW = 2'b10;

    // Predictor storage
    logic                r_valid  [c_DEPTH];
    logic [TAG_BITS-1:0] r_tag    [c_DEPTH];
    logic [XLEN-1:0]     r_target [c_DEPTH];
    logic [1:0]          r_ctr    [c_DEPTH];
    logic [CNT_W-1:0]    r_mis_cnt;

    logic [IDX_BITS-1:0] w_if_idx;
    logic [TAG_BITS-1:0] w_if_tag;
    logic                w_if_hit;
    logic [IDX_BITS-1:0] w_ex_idx;
    logic [TAG_BITS-1:0] w_ex_tag;
    logic                w_ex_hit;
    logic                w_res_valid;
    logic                w_cond;
    logic                w_taken;
    logic                w_mispredict;
    logic                w_unused_pc_bits;

    assign w_if_idx = if_pc[IDX_BITS+1:2];
    assign w_if_tag = if_pc[c_TAG_MSB:c_TAG_LSB];
    assign w_ex_idx = ex_pc[IDX_BITS+1:2];
    assign w_ex_tag = ex_pc[c_TAG_MSB:c_TAG_LSB];

    // PC bits outside the index/tag fields do not participate in lookup
    assign w_unused_pc_bits = ^{if_pc, ex_pc};

    // IF lookup: predict taken only on a tag hit with a counter in the taken half
    always_comb begin
        w_if_hit    = r_valid[w_if_idx] && (r_tag[w_if_idx] == w_if_tag);
        pred_taken  = w_if_hit && r_ctr[w_if_idx][1];
        pred_target = pred_taken ? r_target[w_if_idx] : '0;
    end

    // EX resolution from ALU flags; funct3 010/011 are not branches
    always_comb begin
        w_res_valid = ex_branch;
        w_cond      = 1'b0;
        case (ex_funct3)
            3'b000:          w_cond = ex_zero;
            3'b001:          w_cond = ~ex_zero;
            3'b100, 3'b110:  w_cond = ex_sign;
            3'b101, 3'b111:  w_cond = ~ex_sign;
            default:         w_res_valid = 1'b0;
        endcase
        w_taken      = w_res_valid && w_cond;
        w_mispredict = w_res_valid &&
                       ((w_taken != ex_pred_taken) ||
                        (w_taken && (ex_pred_target != ex_target)));
        w_ex_hit     = r_valid[w_ex_idx] && (r_tag[w_ex_idx] == w_ex_tag);
    end

    assign branch_taken     = w_taken;
    assign mispredict       = w_mispredict;
    assign mispredict_count = r_mis_cnt;

    // Table training; never-taken branches are not allocated
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < c_DEPTH; i++) begin
                r_valid[i]  <= 1'b0;
                r_tag[i]    <= '0;
                r_target[i] <= '0;
                r_ctr[i]    <= c_CTR_RST;
            end
        end else if (w_res_valid) begin
            if (w_ex_hit) begin
                if (w_taken) begin
                    r_target[w_ex_idx] <= ex_target;
                    if (r_ctr[w_ex_idx] != c_CTR_MAX) begin
                        r_ctr[w_ex_idx] <= r_ctr[w_ex_idx] + 2'd1;
                    end
                end else if (r_ctr[w_ex_idx] != c_CTR_MIN) begin
                    r_ctr[w_ex_idx] <= r_ctr[w_ex_idx] - 2'd1;
                end
            end else if (w_taken) begin
                r_valid[w_ex_idx]  <= 1'b1;
                r_tag[w_ex_idx]    <= w_ex_tag;
                r_target[w_ex_idx] <= ex_target;
                r_ctr[w_ex_idx]    <= c_CTR_NEW;
            end
        end
    end

    // Saturating mispredict tally
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_mis_cnt <= '0;
        end else if (w_mispredict && (r_mis_cnt != c_CNT_MAX)) begin
            r_mis_cnt <= r_mis_cnt + 1'b1;
        end
    end

endmodule
`default_nettype wire
